// File: rtl/vector_vector_alu.sv
// Per-chain elementwise ADD/MAX/MIN accumulator with stream or frame commit and a byte-serial config port.
// Optional feature: define VVALU_SATURATE_EN to make ADD saturate instead of wrapping.
module vector_vector_alu #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 1,
  parameter logic [7:0] INITIAL_FIRMWARE_OP     [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0] INITIAL_FIRMWARE_COMMIT [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 tracing,
  input  logic                                 valid_in,
  input  logic                                 eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]        chainId_in,
  input  logic [7:0]                           configId,
  input  logic [7:0]                           configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]         vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]         vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]        chainId_out,
  output logic                                 valid_out,
  output logic                                 eof_out
);

  localparam int CW = $clog2(MAX_CHAINS);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {CFG_IDLE, CFG_OP, CFG_COMMIT} cfg_state_e;
  typedef logic [N-1:0][DW-1:0] vec_t;

  vec_t            acc_q [MAX_CHAINS];
  vec_t            acc_d [MAX_CHAINS];
  logic [MAX_CHAINS-1:0] empty_q, empty_d;
  logic [7:0]      op_q [MAX_CHAINS];
  logic [7:0]      op_d [MAX_CHAINS];
  logic [7:0]      commit_q [MAX_CHAINS];
  logic [7:0]      commit_d [MAX_CHAINS];
  cfg_state_e      cfg_state_q, cfg_state_d;
  logic [CW-1:0]   cfg_chain_q, cfg_chain_d;
  vec_t            vector_out_q, vector_out_d;
  logic [CW-1:0]   chainId_out_q, chainId_out_d;
  logic            valid_out_q, valid_out_d;
  logic            eof_out_q, eof_out_d;

  vec_t            result;
  logic [7:0]      cur_op;
  logic            accum, frame;

  function automatic logic [DW-1:0] lane_op(input logic [7:0] op, input logic empty,
                                            input logic [DW-1:0] a, input logic [DW-1:0] x);
    logic [DW:0]   s;
    logic [DW-1:0] sum;
    s   = {a[DW-1], a} + {x[DW-1], x};
    sum = s[DW-1:0];
`ifdef VVALU_SATURATE_EN
    // Sign of the extended sum disagreeing with its MSB means signed overflow.
    if (s[DW] != s[DW-1]) sum = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    if (op == 8'd0 || op > 8'd3 || empty) return x;
    case (op)
      8'd1:    return sum;
      8'd2:    return ($signed(a) > $signed(x)) ? a : x;
      default: return ($signed(a) < $signed(x)) ? a : x;
    endcase
  endfunction

  always_comb begin
    acc_d         = acc_q;
    empty_d       = empty_q;
    op_d          = op_q;
    commit_d      = commit_q;
    cfg_state_d   = cfg_state_q;
    cfg_chain_d   = cfg_chain_q;
    vector_out_d  = vector_out_q;
    chainId_out_d = chainId_out_q;
    valid_out_d   = 1'b0;
    eof_out_d     = 1'b0;

    cur_op = op_q[chainId_in];
    accum  = (cur_op >= 8'd1) && (cur_op <= 8'd3);
    frame  = (commit_q[chainId_in] == 8'd1);
    for (int i = 0; i < N; i++)
      result[i] = lane_op(cur_op, empty_q[chainId_in], acc_q[chainId_in][i], vector_in[i]);

    if (tracing && valid_in) begin
      if (accum) begin
        acc_d[chainId_in]   = result;
        empty_d[chainId_in] = 1'b0;
      end
      if (!frame || eof_in) begin
        valid_out_d   = 1'b1;
        vector_out_d  = result;
        chainId_out_d = chainId_in;
        eof_out_d     = frame ? 1'b1 : eof_in;
      end
      if (frame && eof_in) begin
        acc_d[chainId_in]   = '0;
        empty_d[chainId_in] = 1'b1;
      end
    end

    // Config is applied after the datapath so a commit-time clear overrides a same-edge update.
    if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      case (cfg_state_q)
        CFG_IDLE: begin
          cfg_chain_d = configData[CW-1:0];
          cfg_state_d = CFG_OP;
        end
        CFG_OP: begin
          op_d[cfg_chain_q] = configData;
          cfg_state_d       = CFG_COMMIT;
        end
        CFG_COMMIT: begin
          commit_d[cfg_chain_q] = configData;
          acc_d[cfg_chain_q]    = '0;
          empty_d[cfg_chain_q]  = 1'b1;
          cfg_state_d           = CFG_IDLE;
        end
        default: cfg_state_d = CFG_IDLE;
      endcase
    end else begin
      cfg_state_d = CFG_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc_q[c]    <= '0;
        op_q[c]     <= INITIAL_FIRMWARE_OP[c];
        commit_q[c] <= INITIAL_FIRMWARE_COMMIT[c];
      end
      empty_q       <= '1;
      cfg_state_q   <= CFG_IDLE;
      cfg_chain_q   <= '0;
      vector_out_q  <= '0;
      chainId_out_q <= '0;
      valid_out_q   <= 1'b0;
      eof_out_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      op_q          <= op_d;
      commit_q      <= commit_d;
      empty_q       <= empty_d;
      cfg_state_q   <= cfg_state_d;
      cfg_chain_q   <= cfg_chain_d;
      vector_out_q  <= vector_out_d;
      chainId_out_q <= chainId_out_d;
      valid_out_q   <= valid_out_d;
      eof_out_q     <= eof_out_d;
    end
  end

  assign vector_out  = vector_out_q;
  assign chainId_out = chainId_out_q;
  assign valid_out   = valid_out_q;
  assign eof_out     = eof_out_q;

endmodule
